// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN image path.
// Ports: none (package). Holds image geometry and the readback FSM state type.
// Imported by img_readback and by the top level that muxes the RAM/UART.
package snn_pkg;

  localparam int NUM_IMG_BITS  = 784;
  localparam int IMG_ADDR_W    = 10;
  localparam int NUM_IMG_BYTES = NUM_IMG_BITS / 8;

  typedef enum logic [2:0] {
    RB_IDLE    = 3'd0,
    RB_FETCH   = 3'd1,
    RB_SEND    = 3'd2,
    RB_WAIT_TX = 3'd3,
    RB_FIN     = 3'd4
  } rb_state_t;

endpackage

// File: rtl/img_readback.sv
// Purpose: dumps the stored binary image from the 1-bit RAM to uart_tx, 8 bits per byte, LSB first.
// Latency: busy the cycle after start; first tx_start 10 cycles after start; done one cycle after last tx_rdy.
// Backpressure: holds in SEND with tx_data stable until tx_rdy; waits on tx_rdy between bytes.
// Ports: clk/rst_n; start in; ram_addr out / ram_q in (1-cycle registered read);
//        tx_data/tx_start out, tx_rdy in; busy/done status out.
module img_readback
  import snn_pkg::*;
#(
  parameter int NUM_BITS = NUM_IMG_BITS,
  parameter int ADDR_W   = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_q,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              done
);

  // Byte index occupies the upper address bits, bit position the lower 3.
  localparam int            KW     = ADDR_W - 3;
  localparam logic [KW-1:0] LAST_K = KW'(NUM_BITS / 8 - 1);

  rb_state_t     state_q, state_d;
  logic [KW-1:0] byte_idx_q, byte_idx_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;   // 0..8 within FETCH
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          guard_q, guard_d;       // first WAIT_TX cycle: tx_rdy not yet deasserted

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_data_q  <= '0;
      guard_q    <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_data_q  <= tx_data_d;
      guard_q    <= guard_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RB_IDLE:    if (start) state_d = RB_FETCH;
      RB_FETCH:   if (bit_cnt_q == 4'd8) state_d = RB_SEND;
      RB_SEND:    if (tx_rdy) state_d = RB_WAIT_TX;
      RB_WAIT_TX: begin
        if (!guard_q && tx_rdy) begin
          state_d = (byte_idx_q == LAST_K) ? RB_FIN : RB_FETCH;
        end
      end
      RB_FIN:     state_d = RB_IDLE;
      default:    state_d = RB_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_data_d  = tx_data_q;
    guard_d    = guard_q;
    unique case (state_q)
      RB_IDLE: begin
        if (start) begin
          byte_idx_d = '0;
          bit_cnt_d  = '0;
          shreg_d    = '0;
        end
      end
      RB_FETCH: begin
        // Count 0 only presents the first address; ram_q is valid from count 1.
        if (bit_cnt_q != 4'd0) begin
          shreg_d = {ram_q, shreg_q[7:1]};
        end
        if (bit_cnt_q == 4'd8) begin
          tx_data_d = {ram_q, shreg_q[7:1]};
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      RB_SEND: begin
        if (tx_rdy) guard_d = 1'b1;
      end
      RB_WAIT_TX: begin
        guard_d = 1'b0;
        if (!guard_q && tx_rdy && (byte_idx_q != LAST_K)) begin
          byte_idx_d = byte_idx_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    ram_addr = '0;
    tx_start = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      RB_IDLE: ;
      RB_FETCH: begin
        busy = 1'b1;
        // Last capture cycle re-presents bit 7 so the address never leaves this byte.
        ram_addr = {byte_idx_q, (bit_cnt_q[3] ? 3'd7 : bit_cnt_q[2:0])};
      end
      RB_SEND: begin
        busy     = 1'b1;
        ram_addr = {byte_idx_q, 3'd0};
        tx_start = tx_rdy;
      end
      RB_WAIT_TX: begin
        busy     = 1'b1;
        ram_addr = {byte_idx_q, 3'd0};
      end
      RB_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        ram_addr = {byte_idx_q, 3'd0};
      end
      default: ;
    endcase
  end

  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_img_readback.sv
module tb_img_readback;
  import snn_pkg::*;

  localparam int NB    = NUM_IMG_BYTES;
  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ram_q = 1'b0;
  logic [9:0] ram_addr;
  logic [7:0] tx_data;
  logic       tx_start;
  wire        tx_rdy;
  logic       busy;
  logic       done;

  img_readback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_rdy   (tx_rdy),
    .busy     (busy),
    .done     (done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Bit RAM model with registered address
  logic       mem [0:1023];
  logic [9:0] addr_l = '0;
  always @(negedge clk) addr_l = ram_addr;
  always @(posedge clk) begin
    #1;
    ram_q = mem[addr_l];
  end

  // UART model: tx_rdy stays high one cycle after tx_start, then FRAME cycles busy
  int   starts_seen = 0;
  int   starts_done = 0;
  bit   pend = 0;
  int   uart_cnt = 0;
  bit   hold_low = 0;
  assign tx_rdy = (uart_cnt == 0) && !hold_low;

  always @(posedge clk) begin
    #1;
    if (pend) begin
      pend = 0;
      uart_cnt = FRAME;
    end else if (uart_cnt > 0) begin
      uart_cnt = uart_cnt - 1;
    end
    if (starts_done != starts_seen) begin
      starts_done = starts_seen;
      pend = 1;
    end
  end

  // Output monitor
  logic [7:0] rx_q[$];
  int         done_cnt = 0;
  int         viol = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      rx_q.push_back(tx_data);
      if (pend || uart_cnt != 0 || !tx_rdy) viol++;
      starts_seen++;
    end
    if (done) done_cnt++;
  end

  typedef struct {
    int         pat;
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[12];

  int run_rx0, run_d0, run_v0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  function automatic logic [7:0] mem_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = mem[8*k+i];
    return b;
  endfunction

  task automatic load_pat(input int p);
    logic [7:0] v;
    for (int a = 0; a < 1024; a++) mem[a] = 1'b0;
    case (p)
      0: mem[0] = 1'b1;
      1: begin mem[7] = 1'b1; mem[783] = 1'b1; end
      default: begin
        for (int k = 0; k < NB; k++) begin
          v = k[7:0];
          for (int i = 0; i < 8; i++) mem[8*k+i] = v[i];
        end
      end
    endcase
  endtask

  task automatic begin_run();
    run_rx0 = rx_q.size();
    run_d0  = done_cnt;
    run_v0  = viol;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit fin_start);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      n++;
      if (n >= budget) break;
    end
    chk("done_timeout", (n < budget) ? 1 : 0, 1);
    if (done && fin_start) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input int p);
    int mism;
    int got;
    chk($sformatf("p%0d_byte_count", p), rx_q.size() - run_rx0, NB);
    chk($sformatf("p%0d_done_count", p), done_cnt - run_d0, 1);
    chk($sformatf("p%0d_tx_rdy_violations", p), viol - run_v0, 0);
    mism = 0;
    for (int k = 0; k < NB; k++) begin
      if (run_rx0 + k >= rx_q.size() || rx_q[run_rx0+k] !== mem_byte(k)) mism++;
    end
    chk($sformatf("p%0d_stream_mismatches", p), mism, 0);
    foreach (vecs[i]) begin
      if (vecs[i].pat == p) begin
        got = (run_rx0 + vecs[i].idx < rx_q.size()) ? int'(rx_q[run_rx0+vecs[i].idx]) : -1;
        chk($sformatf("p%0d_byte%0d", p, vecs[i].idx), got, int'(vecs[i].exp));
      end
    end
  endtask

  initial begin
    logic [7:0] held;
    int         err;
    int         n;
    int         nbusy;

    vecs[0]  = '{0, 0,  8'h01};
    vecs[1]  = '{0, 1,  8'h00};
    vecs[2]  = '{0, 97, 8'h00};
    vecs[3]  = '{1, 0,  8'h80};
    vecs[4]  = '{1, 1,  8'h00};
    vecs[5]  = '{1, 50, 8'h00};
    vecs[6]  = '{1, 97, 8'h80};
    vecs[7]  = '{2, 0,  8'h00};
    vecs[8]  = '{2, 1,  8'h01};
    vecs[9]  = '{2, 53, 8'h35};
    vecs[10] = '{2, 96, 8'h60};
    vecs[11] = '{2, 97, 8'h61};

    // Reset state
    load_pat(0);
    repeat (3) @(negedge clk);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Pattern 0 with start-to-first-byte timing
    begin_run();
    pulse_start();
    chk("t1_busy", busy, 1);
    chk("t1_ram_addr", ram_addr, 0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc <= 8) chk($sformatf("t%0d_ram_addr", cyc), ram_addr, cyc - 1);
      chk($sformatf("t%0d_tx_start", cyc), tx_start, (cyc == 10) ? 1 : 0);
    end
    wait_done(5000, 1'b0);
    check_run(0);

    // Pattern 1 with extra starts while busy and a start during FIN
    load_pat(1);
    begin_run();
    pulse_start();
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    pulse_start();
    wait_done(5000, 1'b1);
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("fin_start_ignored_busy_cycles", nbusy, 0);
    check_run(1);

    // Pattern 2 with a 50-cycle tx_rdy stall on the first byte
    load_pat(2);
    hold_low = 1'b1;
    begin_run();
    pulse_start();
    repeat (10) @(negedge clk);
    held = tx_data;
    err = 0;
    for (int i = 0; i < 50; i++) begin
      if (tx_start !== 1'b0 || tx_data !== held) err++;
      @(negedge clk);
    end
    chk("stall_errors", err, 0);
    chk("stall_tx_data", tx_data, 8'h00);
    hold_low = 1'b0;
    #1;
    chk("stall_release_tx_start", tx_start, 1);
    wait_done(5000, 1'b0);
    check_run(2);

    // Async reset during byte 40's fetch, then a full replay
    begin_run();
    pulse_start();
    n = 0;
    while (!(busy && ram_addr == 10'd323) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("byte40_reached", (n < 5000) ? 1 : 0, 1);
    chk("bytes_before_reset", rx_q.size() - run_rx0, 40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_ram_addr", ram_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    chk("rst_held_no_tx", rx_q.size() - run_rx0, 40);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    begin_run();
    pulse_start();
    wait_done(5000, 1'b0);
    check_run(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
